// File: rtl/mux4x1_data.sv
// 4-to-1 data-flow multiplexer with a combinational result and a one-cycle registered copy.
// Define MUX4X1_DATA_ONEHOT_EN to add a registered one-hot select decode on sel_oh.
module mux4x1_data #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
`ifdef MUX4X1_DATA_ONEHOT_EN
  output logic [3:0]       sel_oh,
`endif
  output logic [1:0]       sel_q
);

  localparam int unsigned SEL_W = 2;
  localparam int unsigned OH_W  = 4;

  logic [WIDTH-1:0] y_d;
  logic [SEL_W-1:0] sel_d;

  // Pure data-flow select; y is independent of clk and rst_n.
  assign y = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);

  always_comb begin
    y_d   = y;
    sel_d = {s1, s0};
  end

  // Capture every cycle; async reset discards any in-flight value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      sel_q <= '0;
    end else begin
      y_q   <= y_d;
      sel_q <= sel_d;
    end
  end

`ifdef MUX4X1_DATA_ONEHOT_EN
  logic [OH_W-1:0] sel_oh_d;
  logic [OH_W-1:0] sel_oh_q;

  // All-zero decode marks "no capture since reset".
  always_comb begin
    sel_oh_d = OH_W'(1) << sel_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_oh_q <= '0;
    end else begin
      sel_oh_q <= sel_oh_d;
    end
  end

  assign sel_oh = sel_oh_q;
`endif

endmodule

// File: tb/tb_mux4x1_data.sv
// Directed self-checking bench for mux4x1_data: a WIDTH=1 instance for the select sweep
// and a WIDTH=8 instance for random, registered, reset and one-hot checks.
module tb_mux4x1_data;

  logic       clk;
  logic       rst_n;
  logic       a_i0, a_i1, a_i2, a_i3, a_s0, a_s1;
  logic       a_y, a_y_q;
  logic [1:0] a_sel_q;
  logic [7:0] b_i0, b_i1, b_i2, b_i3;
  logic       b_s0, b_s1;
  logic [7:0] b_y, b_y_q;
  logic [1:0] b_sel_q;
`ifdef MUX4X1_DATA_ONEHOT_EN
  logic [3:0] a_sel_oh, b_sel_oh;
`endif

  int nvec;
  int nfail;

  mux4x1_data #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i0(a_i0), .i1(a_i1), .i2(a_i2), .i3(a_i3),
    .s0(a_s0), .s1(a_s1),
    .y(a_y), .y_q(a_y_q),
`ifdef MUX4X1_DATA_ONEHOT_EN
    .sel_oh(a_sel_oh),
`endif
    .sel_q(a_sel_q)
  );

  mux4x1_data #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .i0(b_i0), .i1(b_i1), .i2(b_i2), .i3(b_i3),
    .s0(b_s0), .s1(b_s1),
    .y(b_y), .y_q(b_y_q),
`ifdef MUX4X1_DATA_ONEHOT_EN
    .sel_oh(b_sel_oh),
`endif
    .sel_q(b_sel_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ins [4];
    logic [7:0] exp_y;
    logic [1:0] sel;
    logic [1:0] sw_exp;
    nvec  = 0;
    nfail = 0;
    sw_exp = 2'b01;
    rst_n = 1'b0;
    {a_i0, a_i1, a_i2, a_i3, a_s0, a_s1} = '0;
    {b_i0, b_i1, b_i2, b_i3} = '0;
    {b_s0, b_s1} = '0;

    // Reset state: registered outputs held at zero.
    #3;
    check("rst_a_y_q", 64'(a_y_q), 64'h0);
    check("rst_a_sel_q", 64'(a_sel_q), 64'h0);
    check("rst_b_y_q", 64'(b_y_q), 64'h0);
    check("rst_b_sel_q", 64'(b_sel_q), 64'h0);
`ifdef MUX4X1_DATA_ONEHOT_EN
    check("rst_b_sel_oh", 64'(b_sel_oh), 64'h0);
`endif

    // Select sweep on the 1-bit instance: 1,0,1,0.
    {a_i0, a_i1, a_i2, a_i3} = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      {a_s1, a_s0} = 2'(s);
      #5;
      check($sformatf("sweep_y_sel%0d", s), 64'(a_y), 64'(sw_exp[0] ^ 1'(s)));
    end

    // Random combinational vectors on the 8-bit instance.
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 4; j++) ins[j] = 8'($urandom_range(0, 255));
      sel = 2'($urandom_range(0, 3));
      b_i0 = ins[0]; b_i1 = ins[1]; b_i2 = ins[2]; b_i3 = ins[3];
      {b_s1, b_s0} = sel;
      exp_y = ins[sel];
      #1;
      check($sformatf("rand_y_%0d", k), 64'(b_y), 64'(exp_y));
      #4;
    end

    // Registered path.
    @(negedge clk);
    rst_n = 1'b1;
    b_i0 = 8'hA5; b_i1 = 8'h3C; b_i2 = 8'hF0; b_i3 = 8'h0F;
    {b_s1, b_s0} = 2'b00;
    @(posedge clk); #1;
    check("reg_y_q_a5", 64'(b_y_q), 64'hA5);
    check("reg_sel_q_00", 64'(b_sel_q), 64'h0);
    @(negedge clk);
    {b_s1, b_s0} = 2'b11;
    #1;
    check("reg_y_0f_comb", 64'(b_y), 64'h0F);
    check("reg_y_q_hold_a5", 64'(b_y_q), 64'hA5);
    @(posedge clk); #1;
    check("reg_y_q_0f", 64'(b_y_q), 64'h0F);
    check("reg_sel_q_11", 64'(b_sel_q), 64'h3);

    // Async reset between edges.
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_y_q", 64'(b_y_q), 64'h0);
    check("arst_sel_q", 64'(b_sel_q), 64'h0);
    check("arst_y_live", 64'(b_y), 64'h0F);
`ifdef MUX4X1_DATA_ONEHOT_EN
    check("arst_sel_oh", 64'(b_sel_oh), 64'h0);
`endif
    @(posedge clk); #1;
    check("arst_hold_y_q", 64'(b_y_q), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_rel_y_q", 64'(b_y_q), 64'h0F);
    check("arst_rel_sel_q", 64'(b_sel_q), 64'h3);

    // Input change with select fixed at 10.
    @(negedge clk);
    {b_s1, b_s0} = 2'b10;
    b_i2 = 8'h00;
    @(posedge clk); #1;
    check("tog_y_q_0", 64'(b_y_q), 64'h00);
    @(negedge clk);
    b_i2 = 8'h01;
    #1;
    check("tog_y_1", 64'(b_y), 64'h01);
    check("tog_y_q_still_0", 64'(b_y_q), 64'h00);
    @(posedge clk); #1;
    check("tog_y_q_1", 64'(b_y_q), 64'h01);
    check("tog_sel_q_10", 64'(b_sel_q), 64'h2);

    // Select 01 captured; one-hot decode when enabled.
    @(negedge clk);
    {b_s1, b_s0} = 2'b01;
    @(posedge clk); #1;
    check("sel01_y_q", 64'(b_y_q), 64'h3C);
    check("sel01_sel_q", 64'(b_sel_q), 64'h1);
`ifdef MUX4X1_DATA_ONEHOT_EN
    check("sel01_sel_oh", 64'(b_sel_oh), 64'h2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("oh_rst_sel_oh", 64'(b_sel_oh), 64'h0);
    rst_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
